sc_io_responder: RTL and testbench
==================================

Name: sc_io_responder

Overview:
- Memory-mapped I/O responder on the CPU data bus for the I/O half of the address space (addr[7]=1).
- Holds the output-port registers and synchronises the asynchronous device input ports.
- Captures rising edges on in_port0 and provides a down-counting timer.
- Supplies io_read_data to the data-memory read mux; drives an interrupt line.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per input bit (min 2).
- DEBOUNCE_CYCLES, 16, stable cycles required before a debounced input changes (used only with DEBOUNCE_EN).
- TIMER_W, 32, timer counter width (8..32); unused upper read bits are 0.

Ports:
- clock  in  1  system clock, rising-edge.
- clr  in  1  asynchronous active-high reset.
- addr  in  32  CPU byte address; decode uses addr[7] and addr[4:2].
- datain  in  32  CPU store data.
- we  in  1  store strobe, already qualified by the integrating memory block.
- io_read_data  out  32  combinational read data for the selected register.
- out_port0  out  32  output register 0 to device.
- out_port1  out  32  output register 1 to device.
- in_port0  in  32  device input 0, asynchronous.
- in_port1  in  32  device input 1, asynchronous.
- irq  out  1  level interrupt request.

Behaviour:
- Write: on a rising clock edge when we=1 and addr[7]=1, register addr[4:2] is updated. With addr[7]=0, no state changes.
- Register map (byte offset, access):
  - 0x80 OUT0 RW.
  - 0x84 OUT1 RW.
  - 0x88 IN0 RO (synchronised).
  - 0x8C IN1 RO.
  - 0x90 EDGE0 RW1C.
  - 0x94 TIMER RW; a write loads both count and reload.
  - 0x98 CTRL RW: bit0 ten, bit1 reload, bit2 ie_edge, bit3 ie_tmr; bits 31:4 read 0.
  - 0x9C STAT RW1C: bit0 expired.
- Read: io_read_data = register at addr[4:2], combinational, zero cycles. Decode ignores addr[7]; the external mux selects. Writes to RO registers are ignored.
- Reset: all of the following are 0 asynchronously on clr=1, and irq=0:
  - out_port0, out_port1, EDGE0, count, reload, CTRL, STAT;
  - all synchroniser and debounce flops.
- Input latency: in_port change visible in IN0/IN1 after exactly SYNC_STAGES rising edges.
- EDGE0: bit i sets when synced bit i goes 0->1 between consecutive cycles.
  - A write of 1 clears it; a write of 0 has no effect.
  - Set and clear in the same cycle: set wins.
- Timer: when ten=1 and count!=0, count decrements by 1 per cycle.
  - On the 1->0 transition, STAT.expired sets.
  - If reload=1, count loads reload on that same edge instead of reaching 0, so the period is reload cycles.
  - If reload=0, count holds at 0 with no further expiry.
  - ten=0 freezes the count.
  - A TIMER write in the same cycle as an expiring tick: the write wins; no expiry is flagged.
  - STAT clear in the same cycle as an expiry: set wins.
  - Writing 0 to TIMER with ten=1 produces no expiry.
- irq = (ie_edge & |EDGE0) | (ie_tmr & STAT.expired), registered: asserts one cycle after the cause.
- Reset mid-count: the timer stops, count=0, no stale flag after release.

Optional Feature:
- DEBOUNCE_EN defined:
  - Each synced input bit feeds a per-port debounce counter.
  - IN0/IN1 and edge detection update only after the synced value differs from the current debounced value for DEBOUNCE_CYCLES consecutive cycles.
  - Any reversion restarts the count.
  - Latency = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Undefined: no debounce logic; IN0/IN1 are the raw synchroniser outputs.

Test Plan:
- Reset, then write OUT0=0xDEADBEEF with addr=0x80 -> out_port0=0xDEADBEEF next edge; read 0x80 returns the same. Write with addr=0x00 -> out_port0 unchanged.
- in_port1=0x0000_00A5 applied async -> IN1 reads 0xA5 after exactly SYNC_STAGES edges, not before.
- in_port0 bit3 pulses 0->1, CTRL=0x4 -> EDGE0=0x8 and irq=1 one cycle later. Write 0x8 to 0x90 -> EDGE0=0 and irq drops. A new edge coinciding with the clear leaves bit3 set.
- TIMER=3, CTRL=0xB -> expired sets on the 3rd enabled edge, count reloads to 3, irq asserts. Repeat with reload=0 -> count holds at 0 with a single expiry.
- Assert clr while count=5 and EDGE0=0xFF -> all outputs, count and flags read 0; irq=0 after release.
- DEBOUNCE_EN with DEBOUNCE_CYCLES=4: an input glitch lasting 3 cycles -> IN0 unchanged, no edge. A 4-cycle-stable change -> IN0 updates at SYNC_STAGES+4.

Source files
------------

// File: rtl/sc_io_responder.sv
// Memory-mapped I/O responder: output ports, synchronised inputs, rising-edge capture and timer.
// Define DEBOUNCE_EN to insert a per-port debounce stage after the input synchronisers.
module sc_io_responder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMER_W         = 32
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] io_read_data,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic        irq
);

  logic [SYNC_STAGES-1:0][31:0] sync0_q, sync1_q;
  logic [31:0] sync0_out, sync1_out;
  logic [31:0] in0_val, in1_val, in0_prev_q;
  logic [31:0] edge_q, edge_d, rise;
  logic [TIMER_W-1:0] count_q, count_d, reload_q, reload_d;
  logic [3:0] ctrl_q;
  logic stat_q, stat_d, irq_d, expire, tick;
  logic io_wr, timer_wr;

  assign sync0_out = sync0_q[SYNC_STAGES-1];
  assign sync1_out = sync1_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], in_port0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], in_port1};
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DbW-1:0] db0_cnt_q, db1_cnt_q;
  logic [31:0] db0_q, db1_q;

  // Debounced word follows the synced word only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      db0_cnt_q <= '0;
      db1_cnt_q <= '0;
      db0_q     <= '0;
      db1_q     <= '0;
    end else begin
      if (sync0_out == db0_q) begin
        db0_cnt_q <= '0;
      end else if (db0_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        db0_q     <= sync0_out;
        db0_cnt_q <= '0;
      end else begin
        db0_cnt_q <= db0_cnt_q + DbW'(1);
      end
      if (sync1_out == db1_q) begin
        db1_cnt_q <= '0;
      end else if (db1_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        db1_q     <= sync1_out;
        db1_cnt_q <= '0;
      end else begin
        db1_cnt_q <= db1_cnt_q + DbW'(1);
      end
    end
  end

  assign in0_val = db0_q;
  assign in1_val = db1_q;
`else
  assign in0_val = sync0_out;
  assign in1_val = sync1_out;
`endif

  assign io_wr    = we & addr[7];
  assign timer_wr = io_wr & (addr[4:2] == 3'd5);
  assign rise     = in0_val & ~in0_prev_q;
  assign tick     = ctrl_q[0] & (count_q != '0);
  // A TIMER write on the expiring edge suppresses the expiry.
  assign expire   = tick & (count_q == TIMER_W'(1)) & ~timer_wr;

  always_comb begin
    edge_d   = edge_q;
    count_d  = count_q;
    reload_d = reload_q;
    stat_d   = stat_q;
    if (io_wr && addr[4:2] == 3'd4) edge_d = edge_q & ~datain;
    edge_d = edge_d | rise;
    if (timer_wr) begin
      count_d  = datain[TIMER_W-1:0];
      reload_d = datain[TIMER_W-1:0];
    end else if (tick) begin
      count_d = (count_q == TIMER_W'(1) && ctrl_q[1]) ? reload_q : count_q - TIMER_W'(1);
    end
    if (io_wr && addr[4:2] == 3'd7 && datain[0]) stat_d = 1'b0;
    if (expire) stat_d = 1'b1;
    irq_d = (ctrl_q[2] & (|edge_q)) | (ctrl_q[3] & stat_q);
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      out_port0  <= '0;
      out_port1  <= '0;
      in0_prev_q <= '0;
      edge_q     <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      ctrl_q     <= '0;
      stat_q     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (io_wr && addr[4:2] == 3'd0) out_port0 <= datain;
      if (io_wr && addr[4:2] == 3'd1) out_port1 <= datain;
      if (io_wr && addr[4:2] == 3'd6) ctrl_q <= datain[3:0];
      in0_prev_q <= in0_val;
      edge_q     <= edge_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      stat_q     <= stat_d;
      irq        <= irq_d;
    end
  end

  always_comb begin
    io_read_data = '0;
    unique case (addr[4:2])
      3'd0: io_read_data = out_port0;
      3'd1: io_read_data = out_port1;
      3'd2: io_read_data = in0_val;
      3'd3: io_read_data = in1_val;
      3'd4: io_read_data = edge_q;
      3'd5: io_read_data = 32'(count_q);
      3'd6: io_read_data = {28'd0, ctrl_q};
      3'd7: io_read_data = {31'd0, stat_q};
    endcase
  end

endmodule

// File: tb/tb_sc_io_responder.sv
// Directed bench for sc_io_responder: register-map vector table plus multi-cycle sequences
// for input latency, edge capture, timer expiry/reload and asynchronous reset.
module tb_sc_io_responder;

  localparam int SYNC_STAGES = 2;
`ifdef DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = SYNC_STAGES + DB;

  logic        clock;
  logic        clr;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] io_read_data;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        irq;

  int checks = 0;
  int failures = 0;

  sc_io_responder #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(4),
    .TIMER_W        (32)
  ) dut (
    .clock       (clock),
    .clr         (clr),
    .addr        (addr),
    .datain      (datain),
    .we          (we),
    .io_read_data(io_read_data),
    .out_port0   (out_port0),
    .out_port1   (out_port1),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, io_read_data, exp);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h80, 32'hDEADBEEF, 32'h80, 32'hDEADBEEF};
    vecs[1]  = '{32'h00, 32'h12345678, 32'h80, 32'hDEADBEEF};
    vecs[2]  = '{32'h84, 32'hCAFEF00D, 32'h84, 32'hCAFEF00D};
    vecs[3]  = '{32'h04, 32'h11111111, 32'h04, 32'hCAFEF00D};
    vecs[4]  = '{32'h88, 32'hFFFFFFFF, 32'h88, 32'h0};
    vecs[5]  = '{32'h8C, 32'hFFFFFFFF, 32'h8C, 32'h0};
    vecs[6]  = '{32'h98, 32'hFFFFFFFC, 32'h98, 32'hC};
    vecs[7]  = '{32'h98, 32'h0,        32'h98, 32'h0};
    vecs[8]  = '{32'h94, 32'h00001234, 32'h94, 32'h00001234};
    vecs[9]  = '{32'h94, 32'h0,        32'h94, 32'h0};
    vecs[10] = '{32'h9C, 32'hFFFFFFFF, 32'h9C, 32'h0};
    vecs[11] = '{32'h90, 32'hFFFFFFFF, 32'h90, 32'h0};

    clr = 1'b1; addr = '0; datain = '0; we = 1'b0; in_port0 = '0; in_port1 = '0;
    tick(2);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_out0", out_port0, 32'd0);
    chk("rst_out1", out_port1, 32'd0);
    for (int r = 0; r < 8; r++) rd($sformatf("rst_reg%0d", r), 32'h80 + 32'(r * 4), 32'd0);
    clr = 1'b0;
    tick(1);

    // Register map vectors
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end
    chk("port_out0", out_port0, 32'hDEADBEEF);
    chk("port_out1", out_port1, 32'hCAFEF00D);
    chk("irq_idle", {31'd0, irq}, 32'd0);

    // Input synchroniser latency
    in_port1 = 32'hA5;
    tick(LAT - 1);
    rd("in1_early", 32'h8C, 32'h0);
    tick(1);
    rd("in1_lat", 32'h8C, 32'hA5);

`ifdef DEBOUNCE_EN
    in_port0 = 32'h1;
    tick(3);
    in_port0 = 32'h0;
    tick(LAT + 4);
    rd("glitch_in0", 32'h88, 32'h0);
    rd("glitch_edge", 32'h90, 32'h0);
    in_port0 = 32'h1;
    tick(LAT - 1);
    rd("db_early", 32'h88, 32'h0);
    tick(1);
    rd("db_lat", 32'h88, 32'h1);
    in_port0 = 32'h0;
    tick(LAT + 2);
    wr(32'h90, 32'h1);
    rd("db_edge_clr", 32'h90, 32'h0);
`endif

    // Rising-edge capture and interrupt
    wr(32'h98, 32'h4);
    in_port0 = 32'h8;
    tick(LAT);
    rd("in0_lat", 32'h88, 32'h8);
    rd("edge_early", 32'h90, 32'h0);
    tick(1);
    rd("edge_set", 32'h90, 32'h8);
    chk("edge_irq_lag", {31'd0, irq}, 32'd0);
    tick(1);
    chk("edge_irq", {31'd0, irq}, 32'd1);
    wr(32'h90, 32'h8);
    rd("edge_clr", 32'h90, 32'h0);
    tick(1);
    chk("edge_irq_drop", {31'd0, irq}, 32'd0);
    in_port0 = 32'h0;
    tick(LAT + 2);
    rd("edge_fall", 32'h90, 32'h0);
    in_port0 = 32'h8;
    tick(LAT);
    wr(32'h90, 32'h8);
    rd("edge_set_wins", 32'h90, 32'h8);
    wr(32'h90, 32'h8);
    wr(32'h98, 32'h0);

    // Timer with reload
    wr(32'h94, 32'd3);
    wr(32'h98, 32'hB);
    tick(1);
    rd("tmr_c2", 32'h94, 32'd2);
    tick(1);
    rd("tmr_c1", 32'h94, 32'd1);
    rd("tmr_nostat", 32'h9C, 32'd0);
    tick(1);
    rd("tmr_reload", 32'h94, 32'd3);
    rd("tmr_stat", 32'h9C, 32'd1);
    chk("tmr_irq_lag", {31'd0, irq}, 32'd0);
    tick(1);
    chk("tmr_irq", {31'd0, irq}, 32'd1);
    wr(32'h98, 32'h0);
    tick(2);
    rd("tmr_frozen", 32'h94, 32'd1);
    chk("tmr_irq_off", {31'd0, irq}, 32'd0);
    wr(32'h9C, 32'h1);
    rd("tmr_stat_clr", 32'h9C, 32'd0);

    // Timer without reload: single expiry, holds at zero
    wr(32'h94, 32'd3);
    wr(32'h98, 32'h9);
    tick(3);
    rd("one_zero", 32'h94, 32'd0);
    rd("one_stat", 32'h9C, 32'd1);
    tick(3);
    rd("one_hold", 32'h94, 32'd0);
    wr(32'h9C, 32'h1);
    tick(3);
    rd("one_no_reexp", 32'h9C, 32'd0);
    chk("one_irq_off", {31'd0, irq}, 32'd0);

    // Write on the expiring edge wins; writing zero never expires
    wr(32'h94, 32'd1);
    wr(32'h94, 32'd5);
    rd("wwin_count", 32'h94, 32'd5);
    rd("wwin_stat", 32'h9C, 32'd0);
    wr(32'h94, 32'd0);
    tick(2);
    rd("wzero_stat", 32'h9C, 32'd0);

    // STAT clear coinciding with expiry: set wins
    wr(32'h94, 32'd2);
    tick(1);
    wr(32'h9C, 32'h1);
    rd("swin_stat", 32'h9C, 32'd1);
    rd("swin_count", 32'h94, 32'd0);
    wr(32'h98, 32'h0);
    wr(32'h9C, 32'h1);
    rd("swin_clr", 32'h9C, 32'd0);

    // Asynchronous reset mid-count
    in_port0 = 32'h0;
    tick(LAT + 2);
    in_port0 = 32'hFF;
    tick(LAT + 2);
    rd("pre_edge", 32'h90, 32'hFF);
    wr(32'h98, 32'h5);
    wr(32'h94, 32'd5);
    rd("pre_count", 32'h94, 32'd5);
    chk("pre_irq", {31'd0, irq}, 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_out0", out_port0, 32'd0);
    chk("clr_out1", out_port1, 32'd0);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    rd("clr_count", 32'h94, 32'd0);
    rd("clr_edge", 32'h90, 32'd0);
    rd("clr_ctrl", 32'h98, 32'd0);
    rd("clr_in0", 32'h88, 32'd0);
    in_port0 = 32'h0;
    tick(2);
    clr = 1'b0;
    tick(4);
    rd("post_count", 32'h94, 32'd0);
    rd("post_stat", 32'h9C, 32'd0);
    rd("post_edge", 32'h90, 32'd0);
    chk("post_irq", {31'd0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
